// File: rtl/vram_arb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | vram_arb_pkg : shared types for the VRAM arbiter and write FIFO    |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
package vram_arb_pkg;

  localparam int PLANES = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    FETCH_WAIT = 2'd2,
    WRITE      = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [1:0]  plane;
    logic [12:0] loc;
    logic [7:0]  data;
  } wr_entry_t;

  function automatic logic [PLANES-1:0] plane_we(input logic [1:0] plane);
    plane_we        = '0;
    plane_we[plane] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_wfifo.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | vram_wfifo : DEPTH-entry ring of pending CPU writes               |
// | Optional VRAM_ARB_COALESCE_EN merges a repeat write to the newest |
// | queued entry. rev 1.0                                             |
// +-------------------------------------------------------------------+
module vram_wfifo
  import vram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  wr_entry_t                push_entry,
  input  logic                     pop,
  output wr_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     hit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  wr_entry_t     mem [DEPTH];
  logic          alloc;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

`ifdef VRAM_ARB_COALESCE_EN
  wr_entry_t newest;
  assign newest = mem[wr_ptr - AW'(1)];
  // The newest entry is only mergeable if this same clock does not pop it.
  assign hit = !empty && !(pop && count == CW'(1)) &&
               newest.plane == push_entry.plane && newest.loc == push_entry.loc;
`else
  assign hit = 1'b0;
`endif

  assign alloc = push && !hit;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({alloc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_sys) begin
    if (alloc) begin
      mem[wr_ptr] <= push_entry;
    end else if (push && hit) begin
      mem[wr_ptr - AW'(1)].data <= push_entry.data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | vram_arbiter : single-port VRAM arbiter, display fetch over CPU   |
// | writes; honours VRAM_ARB_COALESCE_EN via vram_wfifo. rev 1.0      |
// +-------------------------------------------------------------------+
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_din,
  input  logic               cpu_we,
  output logic               cpu_wait,
  input  logic               fetch_req,
  input  logic [12:0]        fetch_addr,
  output logic               fetch_valid,
  output logic [31:0]        fetch_data,
  output logic [12:0]        ram_addr,
  output logic [PLANES-1:0]  ram_we,
  output logic [7:0]         ram_wdata,
  input  logic [31:0]        ram_q
);

  localparam int CW = $clog2(DEPTH) + 1;

  arb_state_t    state;
  logic          fetch_pend;
  logic [12:0]   fetch_pend_addr;

  wr_entry_t     push_entry;
  wr_entry_t     head;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          hit;
  logic [CW-1:0] count;

  assign push_entry = {cpu_addr[14:13], cpu_addr[12:0], cpu_din};
  assign push       = cpu_we && cpu_addr[15] && (!full || hit);
  assign pop        = (state == IDLE || state == WRITE) && !fetch_pend && !empty;
  assign cpu_wait   = (count == CW'(DEPTH));

  vram_wfifo #(.DEPTH(DEPTH)) u_wfifo (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .hit        (hit)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state           <= IDLE;
      fetch_pend      <= 1'b0;
      fetch_pend_addr <= '0;
      fetch_valid     <= 1'b0;
      fetch_data      <= '0;
      ram_addr        <= '0;
      ram_we          <= '0;
      ram_wdata       <= '0;
    end else begin
      fetch_valid <= 1'b0;
      if (fetch_req) begin
        fetch_pend      <= 1'b1;
        fetch_pend_addr <= fetch_addr;
      end
      case (state)
        IDLE, WRITE: begin
          if (fetch_pend) begin
            state    <= FETCH;
            ram_addr <= fetch_pend_addr;
            ram_we   <= '0;
            // A request landing on this very clock stays pending.
            if (!fetch_req) fetch_pend <= 1'b0;
          end else if (!empty) begin
            state     <= WRITE;
            ram_addr  <= head.loc;
            ram_wdata <= head.data;
            ram_we    <= plane_we(head.plane);
          end else begin
            state  <= IDLE;
            ram_we <= '0;
          end
        end
        FETCH: begin
          state <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          fetch_data  <= ram_q;
          fetch_valid <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// tb_vram_arbiter : directed and random traffic checked against a
// transaction-level model of the VRAM contents and write queue.
module tb_vram_arbiter;

  localparam int DEPTH = 4;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic        cpu_wait;
  logic        fetch_req;
  logic [12:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic [12:0] ram_addr;
  logic [3:0]  ram_we;
  logic [7:0]  ram_wdata;
  logic [31:0] ram_q;

  always #5 clk_sys = ~clk_sys;

  vram_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_we      (cpu_we),
    .cpu_wait    (cpu_wait),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_q       (ram_q)
  );

  function automatic logic [7:0] init_byte(input int p, input int a);
    return 8'(a * 7 + p * 61 + 90);
  endfunction

  // Synchronous VRAM behind the arbiter port; unwritten bytes read the init pattern.
  logic [7:0] vram [4][8192];
  bit         vwr  [4][8192];

  function automatic logic [7:0] vram_rd(input int p, input logic [12:0] a);
    return vwr[p][a] ? vram[p][a] : init_byte(p, int'(a));
  endfunction

  always @(posedge clk_sys) begin
    for (int p = 0; p < 4; p++) begin
      if (ram_we[p]) begin
        vram[p][ram_addr] <= ram_wdata;
        vwr[p][ram_addr]  <= 1'b1;
      end
    end
    ram_q <= {vram_rd(3, ram_addr), vram_rd(2, ram_addr), vram_rd(1, ram_addr), vram_rd(0, ram_addr)};
  end

  // Reference model: expected VRAM bytes and the queue of accepted writes.
  typedef struct {
    logic [1:0]  plane;
    logic [12:0] loc;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  model_mem [4][8192];
  int          cyc;
  int          fetch_k;
  logic [12:0] fetch_exp_addr;
  int          tests;
  int          fails;
  int          n_8010;
  logic [7:0]  last_8010;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input logic we, input logic [15:0] a, input logic [7:0] d,
                      input logic fr, input logic [12:0] fa);
    int  pre;
    int  since;
    bit  expect_wr;
    bit  hit;
    wr_t e;
    cpu_we = we; cpu_addr = a; cpu_din = d; fetch_req = fr; fetch_addr = fa;
    @(posedge clk_sys);
    @(negedge clk_sys);
    cpu_we = 1'b0; fetch_req = 1'b0;
    cyc++;
    pre   = exp_q.size();
    since = cyc - fetch_k;
    // A fetch owns the port for the three clocks after it is sampled.
    expect_wr = (pre > 0) && !(since >= 1 && since <= 3);
    if (expect_wr) begin
      e = exp_q.pop_front();
      check_eq("ram_write", {ram_we, ram_addr, ram_wdata}, {4'b0001 << e.plane, e.loc, e.data});
      model_mem[e.plane][e.loc] = e.data;
      if (e.plane == 2'd0 && e.loc == 13'h0010) begin
        n_8010++;
        last_8010 = e.data;
      end
    end else begin
      check_eq("ram_we_idle", {28'd0, ram_we}, 32'd0);
    end
    if (we && a[15]) begin
      hit = 1'b0;
`ifdef VRAM_ARB_COALESCE_EN
      if (exp_q.size() > 0 && exp_q[exp_q.size()-1].plane == a[14:13] &&
          exp_q[exp_q.size()-1].loc == a[12:0]) hit = 1'b1;
`endif
      if (hit) begin
        e = exp_q[exp_q.size()-1];
        e.data = d;
        exp_q[exp_q.size()-1] = e;
      end else if (pre < DEPTH) begin
        e.plane = a[14:13]; e.loc = a[12:0]; e.data = d;
        exp_q.push_back(e);
      end
    end
    check_eq("cpu_wait", {31'd0, cpu_wait}, {31'd0, exp_q.size() == DEPTH});
    check_eq("fetch_valid", {31'd0, fetch_valid}, {31'd0, cyc == fetch_k + 3});
    if (cyc == fetch_k + 3)
      check_eq("fetch_data", fetch_data,
               {model_mem[3][fetch_exp_addr], model_mem[2][fetch_exp_addr],
                model_mem[1][fetch_exp_addr], model_mem[0][fetch_exp_addr]});
    if (fr) begin
      fetch_k = cyc;
      fetch_exp_addr = fa;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 16'h0, 8'h0, 1'b0, 13'h0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0; cpu_we = 1'b0; fetch_req = 1'b0;
    cyc += n;
    exp_q.delete();
    fetch_k = -100;
    check_eq("rst_ram_we", {28'd0, ram_we}, 32'd0);
    check_eq("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    check_eq("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check_eq("rst_fetch_data", fetch_data, 32'd0);
    check_eq("rst_ram_addr", {19'd0, ram_addr}, 32'd0);
    check_eq("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
  endtask

  initial begin
    int          next_f;
    logic        rwe;
    logic        rfr;
    logic [15:0] ra;
    reset = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    fetch_req = 1'b0; fetch_addr = '0;
    tests = 0; fails = 0; cyc = 0; fetch_k = -100; n_8010 = 0; last_8010 = '0;
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < 8192; a++)
        model_mem[p][a] = init_byte(p, a);

    do_reset(2);
    idle(10);

    // Single write, then read it back through a fetch.
    tick(1'b1, 16'hC123, 8'hA5, 1'b0, 13'h0);
    idle(1);
    check_eq("wr_a5", {4'b0, ram_we, ram_addr, ram_wdata}, {4'b0, 4'b0100, 13'h0123, 8'hA5});
    idle(3);
    tick(1'b0, 16'h0, 8'h0, 1'b1, 13'h0123);
    idle(3);
    check_eq("fetch_a5", {24'd0, fetch_data[23:16]}, 32'h0000_00A5);
    idle(4);

    // Four writes queue up behind one fetch, a second fetch preempts the drain.
    tick(1'b1, 16'h8040, 8'h41, 1'b1, 13'h0100);
    tick(1'b1, 16'hA040, 8'h42, 1'b0, 13'h0);
    tick(1'b1, 16'hC040, 8'h43, 1'b0, 13'h0);
    tick(1'b1, 16'hE040, 8'h44, 1'b0, 13'h0);
    tick(1'b0, 16'h0,    8'h00, 1'b1, 13'h0040);
    idle(10);
    tick(1'b0, 16'h0, 8'h0, 1'b1, 13'h0040);
    idle(3);
    check_eq("four_landed", fetch_data, 32'h4443_4241);
    idle(4);

    // Fill to DEPTH; the fifth write is strobed while full and must vanish.
    tick(1'b1, 16'h8301, 8'h31, 1'b1, 13'h0100);
    tick(1'b1, 16'hA302, 8'h32, 1'b0, 13'h0);
    tick(1'b1, 16'hC303, 8'h33, 1'b0, 13'h0);
    tick(1'b1, 16'hE304, 8'h34, 1'b0, 13'h0);
    check_eq("wait_full", {31'd0, cpu_wait}, 32'd1);
    tick(1'b1, 16'hE777, 8'h99, 1'b1, 13'h0777);
    idle(10);
    tick(1'b0, 16'h0, 8'h0, 1'b1, 13'h0777);
    idle(3);
    check_eq("dropped_absent", {24'd0, fetch_data[31:24]}, {24'd0, init_byte(3, 'h777)});
    idle(4);

    // Two writes to the same location while a fetch blocks the port.
    n_8010 = 0;
    tick(1'b1, 16'h8010, 8'h11, 1'b1, 13'h0010);
    tick(1'b1, 16'h8010, 8'h22, 1'b0, 13'h0);
    idle(8);
`ifdef VRAM_ARB_COALESCE_EN
    check_eq("coalesce_count", n_8010, 1);
`else
    check_eq("coalesce_count", n_8010, 2);
`endif
    check_eq("coalesce_last", {24'd0, last_8010}, 32'h22);

    // Reset while in FETCH with writes queued.
    tick(1'b1, 16'h8200, 8'h51, 1'b1, 13'h0200);
    tick(1'b1, 16'hA200, 8'h52, 1'b0, 13'h0);
    cpu_we = 1'b1; cpu_addr = 16'hC200; cpu_din = 8'h53;
    do_reset(1);
    idle(8);

    // Random traffic with fetches spaced 4..9 clocks apart.
    next_f = cyc + 4;
    for (int i = 0; i < 400; i++) begin
      rwe = ($urandom_range(0, 3) != 0);
      ra  = {($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 13'($urandom_range(0, 7))};
      rfr = (cyc + 1 >= next_f);
      if (rfr) next_f = cyc + 1 + int'($urandom_range(4, 9));
      tick(rwe, ra, 8'($urandom), rfr, 13'($urandom_range(0, 7)));
    end
    idle(12);
    check_eq("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
